decode: RTL and testbench

- Decode-stage integer register file: 32 x 32-bit, two read ports, one write port.
- Register 0 is hardwired to zero.
- Read data is registered: it is presented on the cycle after the read address is sampled.
- Sits between instruction decode (register numbers) and execute/writeback (operand data, result writeback).

---
 rtl/decode.sv | 56 +++++
 tb/tb_decode.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode-stage register file: 2**ADDR_WIDTH x DATA_WIDTH, two registered read ports, one write port.
// Optional macro DECODE_BYPASS_EN: read/write collisions return the new write data (write-first).
module decode #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_en,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] regNum0,
    output logic [DATA_WIDTH-1:0] dataOut0,
    input  logic [ADDR_WIDTH-1:0] regNum1,
    output logic [DATA_WIDTH-1:0] dataOut1,
    input  logic [ADDR_WIDTH-1:0] wRegNum,
    input  logic [DATA_WIDTH-1:0] wDataIn
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 is never stored; it reads as zero.
    logic [DATA_WIDTH-1:0] reg_mem [1:DEPTH-1];

    logic                  wr_act;
    logic [DATA_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0] rd1;

    assign wr_act = writeEnable && (wRegNum != '0);

    always_comb begin
        rd0 = '0;
        rd1 = '0;
        if (regNum0 != '0) rd0 = reg_mem[regNum0];
        if (regNum1 != '0) rd1 = reg_mem[regNum1];
`ifdef DECODE_BYPASS_EN
        // wr_act already excludes register 0, so a zero read stays zero.
        if (wr_act && (regNum0 == wRegNum)) rd0 = wDataIn;
        if (wr_act && (regNum1 == wRegNum)) rd1 = wDataIn;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                reg_mem[ADDR_WIDTH'(i)] <= '0;
            end
            dataOut0 <= '0;
            dataOut1 <= '0;
        end else if (chip_en) begin
            if (wr_act) reg_mem[wRegNum] <= wDataIn;
            dataOut0 <= rd0;
            dataOut1 <= rd1;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed cases plus randomized traffic against an array model.
module tb_decode;

    logic        clk;
    logic        reset;
    logic        chip_en;
    logic        writeEnable;
    logic [4:0]  regNum0;
    logic [31:0] dataOut0;
    logic [4:0]  regNum1;
    logic [31:0] dataOut1;
    logic [4:0]  wRegNum;
    logic [31:0] wDataIn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [0:31];
    logic [31:0] exp0;
    logic [31:0] exp1;

    decode #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) DUT (
        .clk(clk), .reset(reset), .chip_en(chip_en), .writeEnable(writeEnable),
        .regNum0(regNum0), .dataOut0(dataOut0), .regNum1(regNum1), .dataOut1(dataOut1),
        .wRegNum(wRegNum), .wDataIn(wDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 1; i < 32; i++) check($sformatf("%s mem[%0d]", tag, i), DUT.reg_mem[5'(i)], mdl[i]);
    endtask

    task automatic clear_all();
        for (int i = 1; i < 32; i++) begin
            DUT.reg_mem[5'(i)] = '0;
            mdl[i] = '0;
        end
    endtask

    // Model: a read sees the array either before or after this edge's write.
    task automatic step(input logic ce, input logic we, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] wr, input logic [31:0] wd);
        chip_en = ce; writeEnable = we; regNum0 = r0; regNum1 = r1; wRegNum = wr; wDataIn = wd;
        @(posedge clk);
        if (ce) begin
`ifdef DECODE_BYPASS_EN
            if (we && wr != 0) mdl[wr] = wd;
            exp0 = mdl[r0];
            exp1 = mdl[r1];
`else
            exp0 = mdl[r0];
            exp1 = mdl[r1];
            if (we && wr != 0) mdl[wr] = wd;
`endif
        end
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag);
        check({tag, " dataOut0"}, dataOut0, exp0);
        check({tag, " dataOut1"}, dataOut1, exp1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        exp0 = '0; exp1 = '0;
        reset = 1'b0; chip_en = 1'b0; writeEnable = 1'b0;
        regNum0 = '0; regNum1 = '0; wRegNum = '0; wDataIn = '0;
        repeat (2) @(negedge clk);
        check_outs("reset");
        check("reset mem[31]", DUT.reg_mem[31], 32'h0);
        reset = 1'b1;

        // Asynchronous reset between edges
        step(1'b1, 1'b1, 5'd1, 5'd2, 5'd9, 32'h5555_0009);
        DUT.reg_mem[5] = 32'h1234; mdl[5] = 32'h1234;
        #2 reset = 1'b0;
        #1;
        for (int i = 1; i < 32; i++) mdl[i] = '0;
        exp0 = '0; exp1 = '0;
        check_outs("async reset");
        check("async reset mem[5]", DUT.reg_mem[5], 32'h0);
        check("async reset mem[9]", DUT.reg_mem[9], 32'h0);
        @(posedge clk);
        check("reset held mem[5]", DUT.reg_mem[5], 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Walking write then read-only readback
        for (int i = 1; i < 32; i++) begin
            clear_all();
            step(1'b1, 1'b1, 5'd0, 5'd0, 5'(i), 32'(i));
            check_mem($sformatf("walk %0d", i));
            step(1'b1, 1'b0, 5'(i), 5'(i), 5'(i), 32'hF0F0_F0F0);
            check_outs($sformatf("readonly %0d", i));
            check($sformatf("readonly keep %0d", i), DUT.reg_mem[5'(i)], 32'(i));
        end

        // Register 0
        clear_all();
        DUT.reg_mem[4] = 32'h4444; mdl[4] = 32'h4444;
        step(1'b1, 1'b1, 5'd0, 5'd4, 5'd0, 32'hDEAD_BEEF);
        check_outs("reg0");
        check("reg0 dataOut0 zero", dataOut0, 32'h0);
        check_mem("reg0");

        // Enable gating
        DUT.reg_mem[7] = 32'h77; mdl[7] = 32'h77;
        step(1'b1, 1'b0, 5'd7, 5'd4, 5'd0, 32'h0);
        step(1'b0, 1'b1, 5'd1, 5'd2, 5'd7, 32'hAA);
        check_outs("gated");
        check("gated dataOut0 hold", dataOut0, 32'h77);
        check("gated mem[7]", DUT.reg_mem[7], 32'h77);

        // Collision
        DUT.reg_mem[3] = 32'h11; mdl[3] = 32'h11;
        step(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'h22);
        check_outs("collision");
`ifdef DECODE_BYPASS_EN
        check("collision bypass", dataOut0, 32'h22);
`else
        check("collision readfirst", dataOut0, 32'h11);
`endif
        check("collision mem[3]", DUT.reg_mem[3], 32'h22);

        // Randomized traffic with address bias toward collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a0, a1, aw;
            aw = 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 7) != 0), 1'($urandom), a0, a1, aw, $urandom);
            check_outs($sformatf("rand %0d", n));
            if (n % 50 == 49) check_mem($sformatf("rand %0d", n));
        end
        check_mem("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
